// File: rtl/lsu_byte_sequencer_if.sv
// Request/response channel between the execute stage (master) and the LSU byte
// sequencer (slave).
interface lsu_byte_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Splits byte/half/word load-store requests into single-byte memory accesses,
// one per clock, and returns an extended load result or an alignment error.
module lsu_byte_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  lsu_byte_sequencer_if.slave  bus,
  output logic [ADDR_W-1:0]    mem_wr_add_o,
  output logic [7:0]           mem_wr_data_o,
  output logic                 mem_sw_o,
  output logic [ADDR_W-1:0]    mem_rd_add_o,
  input  logic [7:0]           mem_rd_data_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic              req_legal;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_addr;
  logic [4:0]        lane_base;
  logic [DATA_W-1:0] ext_data;

  always_comb begin
    unique case (bus.req_size)
      2'b00:   req_legal = 1'b1;
      2'b01:   req_legal = ~bus.req_addr[0];
      2'b10:   req_legal = (bus.req_addr[1:0] == 2'b00);
      default: req_legal = 1'b0;
    endcase
  end

  // Only legal sizes reach ACCESS, so size_q is 00, 01 or 10 here.
  assign last_beat = (cnt_q == ((size_q == 2'b10) ? 2'd3 : {1'b0, size_q[0]}));
  assign beat_addr = addr_q + ADDR_W'(cnt_q);
  assign lane_base = {cnt_q, 3'b000};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 2'd0;
          data_d  = '0;
          err_d   = ~req_legal;
          state_d = req_legal ? StAccess : StDone;
        end
      end
      StAccess: begin
        if (!we_q) data_d[lane_base +: 8] = mem_rd_data_i;
        if (last_beat) state_d = StDone;
        else           cnt_d   = cnt_q + 2'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    unique case (size_q)
      2'b00:   ext_data = {{(DATA_W-8){~uns_q & data_q[7]}}, data_q[7:0]};
      2'b01:   ext_data = {{(DATA_W-16){~uns_q & data_q[15]}}, data_q[15:0]};
      default: ext_data = data_q;
    endcase
  end

  // All outputs decode straight from state so reset clears them asynchronously.
  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    bus.resp_valid = (state_q == StDone);
    bus.resp_err   = (state_q == StDone) & err_q;
    bus.resp_rdata = ((state_q == StDone) && !err_q) ? ext_data : '0;
    mem_wr_add_o   = '0;
    mem_rd_add_o   = '0;
    mem_wr_data_o  = 8'h00;
    mem_sw_o       = 1'b0;
    if (state_q == StAccess) begin
      mem_wr_add_o = beat_addr;
      mem_rd_add_o = beat_addr;
      if (we_q) begin
        mem_sw_o      = 1'b1;
        mem_wr_data_o = wdata_q[lane_base +: 8];
      end
    end
  end

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
- Load/store initiator sitting between the execute stage and the byte-wide data memory (32 entries x 8 bits, 5-bit address, single write strobe, combinational read).
- Accepts one byte, half or word load/store request and splits it into 1, 2 or 4 byte accesses, one per clock.
- Returns a sign- or zero-extended 32-bit load result, or an alignment error.

Parameters:
- ADDR_W, 5, byte address width; data memory depth is 2^ADDR_W.
- DATA_W, 32, request and response data width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address, little-endian.
- req_wdata  in  DATA_W  store data; low bytes used for byte/half.
- resp_valid  out  1  one-cycle pulse; transaction complete.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; misaligned or illegal size.
- mem_wr_add  out  ADDR_W  memory write address.
- mem_wr_data  out  8  memory write byte.
- mem_sw  out  1  memory write strobe.
- mem_rd_add  out  ADDR_W  memory read address.
- mem_rd_data  in  8  memory read byte, combinational from mem_rd_add.

Behaviour:
- Reset (asynchronous): state IDLE, byte counter 0, all latched request fields 0, req_ready 1, resp_valid 0, resp_err 0, resp_rdata 0, mem_sw 0, all mem addresses and mem_wr_data 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Handshake occurs on req_valid & req_ready at a rising edge.
  - On handshake, latch we, size, unsigned, addr, wdata; clear counter and assembly register.
  - Go to ACCESS if legal, else DONE with error flag set.
  - req_valid while not ready is ignored; the requester holds it.
- Legality: size 11 is illegal; half with addr[0]=1 is misaligned; word with addr[1:0]!=00 is misaligned.
  - An illegal request performs no memory access (mem_sw never asserted).
  - It produces resp_valid with resp_err=1 and resp_rdata=0 one cycle after the handshake.
- ACCESS, beat count N = 1, 2 or 4:
  - Beat k drives mem_rd_add and mem_wr_add = latched addr + k.
  - Alignment guarantees no address wrap; a word at 28 covers bytes 28..31.
  - Store beat: mem_sw=1 and mem_wr_data = wdata[8k+7:8k] for that cycle.
  - Load beat: mem_sw=0; mem_rd_data is captured into byte lane k at the closing edge.
  - After beat N-1, go to DONE.
- DONE (exactly one cycle): resp_valid=1, then return to IDLE.
  - req_ready is low in DONE, so back-to-back requests have one bubble.
- Latency: handshake at edge T; beats occupy cycles T+1..T+N; resp_valid in cycle T+N+1.
  - Byte load/store takes 3 cycles handshake-to-handshake, half 4, word 6.
- Load extension:
  - Byte: bit 7 replicated into [31:8] when signed, else zeros.
  - Half: bit 15 replicated into [31:16] when signed, else zeros.
  - Word: no extension.
- resp_rdata and resp_err are meaningful only while resp_valid is high; they are held at 0 otherwise.
- mem_sw is asserted only in store ACCESS cycles; never in IDLE, DONE, or on error.
- Reset mid-transaction: immediate abort, mem_sw deasserts asynchronously, no resp_valid.
  - Bytes already written stay written; no rollback.

Test Plan:
- Reset held 3 cycles, then released -> req_ready=1, resp_valid=0, mem_sw=0; assert rst mid word-store after beat 1 -> mem_sw drops same cycle, bytes 8,9 written, 10,11 untouched, no resp_valid.
- Word store addr=8, wdata=0xDEADBEEF, then word load addr=8 -> store: mem_sw high 4 cycles with bytes EF,BE,AD,DE at 8..11, resp_valid at T+5, err=0; load: resp_rdata=0xDEADBEEF.
- Memory byte 5 = 0x80: signed byte load addr=5 -> 0xFFFFFF80; unsigned -> 0x00000080, each with resp_valid at T+2.
- Half store addr=30, wdata=0x0000F00D, signed half load addr=30 -> bytes 0D at 30 and F0 at 31; load result 0xFFFFF00D; unsigned load -> 0x0000F00D.
- Word load addr=6, half load addr=3, size=11 addr=0 -> each gives resp_err=1, resp_rdata=0, resp_valid at T+1, mem_sw never asserted.
- req_valid held high continuously with byte loads at addrs 0,1,2 -> handshakes exactly 3 cycles apart, req_ready low in ACCESS/DONE, responses in address order.
